// File: rtl/definitions_pkg.sv
// Shared execute-stage definitions: machine word, divider op codes and FSM states.
// XLEN_DEF is 64 when RV64 is defined, otherwise 32.
// Optional divider feature macro used elsewhere: DIV_FAST_SPECIAL_EN.
package definitions_pkg;

`ifdef RV64
    localparam int XLEN_DEF = 64;
`else
    localparam int XLEN_DEF = 32;
`endif

    typedef logic [XLEN_DEF-1:0] word_st;

    typedef enum logic [1:0] {
        DIV_S = 2'd0,
        DIV_U = 2'd1,
        REM_S = 2'd2,
        REM_U = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Iterations needed by a W-variant (32-bit) division.
    localparam int DIV_W_ITERS = 32;

    function automatic logic div_is_signed(input div_op_e op);
        return (op == DIV_S) || (op == REM_S);
    endfunction

    function automatic logic div_is_rem(input div_op_e op);
        return (op == REM_S) || (op == REM_U);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring division step: shift {rem,quo} left, trial-subtract divisor.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    // Partial remainder gains one extra bit after the shift, so subtract at XLEN+1 width.
    assign w_shift = {rem_i, quo_i[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, divisor_i};
    assign w_fits  = ~w_diff[XLEN];

    assign rem_o = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU (+ W variants under RV64).
// Latency: N+1 cycles from handshake (N = 32 or XLEN); special cases 1 cycle with DIV_FAST_SPECIAL_EN.
// Backpressure: ready_o only in IDLE; result held in DONE until ready_i; flush_i kills any state.
module div_unit
    import definitions_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  div_op_e         div_op_i,
    input  logic            word_32_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);

    // Extend the low 32 bits to XLEN (sign or zero) when w is set; pass through otherwise.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic w, input logic s);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = (i < 32) ? x[i] : (s & x[31]);
        end
        return w ? r : x;
    endfunction

    div_state_e      r_state;
    div_op_e         r_op;
    logic            r_word;
    logic            r_sign_q;
    logic            r_sign_r;
    logic            r_special;
    logic [XLEN-1:0] r_spec_val;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_cnt;

    logic            w_word;
    logic            w_signed;
    logic            w_is_rem;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_min_neg;
    logic [XLEN-1:0] w_spec_raw;
    logic [XLEN-1:0] w_spec_ext;
    logic [XLEN-1:0] w_quo_init;
    logic [CW-1:0]   w_iters;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_fin;
    logic            w_accept;

    // Operand preparation at acceptance; W flag only meaningful on a 64-bit datapath.
    assign w_word   = (XLEN > 32) ? word_32_i : 1'b0;
    assign w_signed = div_is_signed(div_op_i);
    assign w_is_rem = div_is_rem(div_op_i);
    assign w_a_ext  = ext32(src_a_i, w_word, w_signed);
    assign w_b_ext  = ext32(src_b_i, w_word, w_signed);
    assign w_sign_a = w_signed & w_a_ext[XLEN-1];
    assign w_sign_b = w_signed & w_b_ext[XLEN-1];
    assign w_mag_a  = w_sign_a ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_mag_b  = w_sign_b ? (~w_b_ext + 1'b1) : w_b_ext;

    // Architectural special cases, resolved up front and forced at DONE entry.
    assign w_min_neg  = w_word ? ext32(XLEN'(32'h8000_0000), 1'b1, 1'b1)
                               : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0     = (w_b_ext == '0);
    assign w_ovf      = w_signed & ~w_div0 & (w_a_ext == w_min_neg) & (w_b_ext == '1);
    assign w_spec_raw = w_div0 ? (w_is_rem ? w_a_ext : '1) : (w_is_rem ? '0 : w_a_ext);
    assign w_spec_ext = ext32(w_spec_raw, w_word, 1'b1);

    // A W dividend sits in the top half so that 32 shifts consume exactly its bits.
    assign w_quo_init = w_word ? (w_mag_a << (XLEN - DIV_W_ITERS)) : w_mag_a;
    assign w_iters    = w_word ? CW'(DIV_W_ITERS) : CW'(XLEN);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (r_rem),
        .quo_i     (r_quo),
        .divisor_i (r_divisor),
        .rem_o     (w_rem_nxt),
        .quo_o     (w_quo_nxt)
    );

    // Final result from the last step's outputs, with sign fix-up and W sign-extension.
    assign w_q_fin = r_sign_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_r_fin = r_sign_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_fin   = r_special ? r_spec_val
                               : ext32(div_is_rem(r_op) ? w_r_fin : w_q_fin, r_word, 1'b1);

    assign w_accept = (r_state == DIV_IDLE) & valid_i & ~flush_i;
    assign ready_o  = (r_state == DIV_IDLE);
    assign valid_o  = (r_state == DIV_DONE);
    assign result_o = r_result;

    // FSM, iteration datapath and result register; flush wins over everything but reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= DIV_IDLE;
            r_op       <= DIV_S;
            r_word     <= 1'b0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
        end else if (flush_i) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_op       <= div_op_i;
                        r_word     <= w_word;
                        r_sign_q   <= w_sign_a ^ w_sign_b;
                        r_sign_r   <= w_sign_a;
                        r_special  <= w_div0 | w_ovf;
                        r_spec_val <= w_spec_ext;
                        r_rem      <= '0;
                        r_quo      <= w_quo_init;
                        r_divisor  <= w_mag_b;
                        r_cnt      <= w_iters;
`ifdef DIV_FAST_SPECIAL_EN
                        if (w_div0 || w_ovf) begin
                            r_state  <= DIV_DONE;
                            r_result <= w_spec_ext;
                        end else begin
                            r_state <= DIV_CALC;
                        end
`else
                        r_state <= DIV_CALC;
`endif
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state  <= DIV_DONE;
                        r_result <= w_fin;
                    end
                end
                DIV_DONE: begin
                    if (ready_i) begin
                        r_state <= DIV_IDLE;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results and latencies.
// Covers directed vectors, special cases, backpressure, flush, async reset, random ops.
// Honors DIV_FAST_SPECIAL_EN and RV64 the same way the design does.
module tb_div_unit;
    import definitions_pkg::*;

    localparam int XLEN = XLEN_DEF;
`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    div_op_e         div_op_i = DIV_S;
    logic            word_32_i = 1'b0;
    logic [XLEN-1:0] src_a_i = '0;
    logic [XLEN-1:0] src_b_i = '0;
    logic            flush_i = 1'b0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [XLEN-1:0] result_o;

    div_unit #(.XLEN(XLEN)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .div_op_i  (div_op_i),
        .word_32_i (word_32_i),
        .src_a_i   (src_a_i),
        .src_b_i   (src_b_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] exp_q[$];
    int              lat_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] x, input logic w, input logic s);
        logic [XLEN-1:0] r = x;
        if (w) for (int i = 32; i < XLEN; i++) r[i] = s & x[31];
        return r;
    endfunction

    // Reference result built on the simulator's own / and % operators.
    function automatic logic [XLEN-1:0] ref_res(input div_op_e op, input logic w,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                output logic spec);
        logic s   = (op == DIV_S) || (op == REM_S);
        logic rem = (op == REM_S) || (op == REM_U);
        logic [XLEN-1:0] ae = ext(a, w, s);
        logic [XLEN-1:0] be = ext(b, w, s);
        logic [XLEN-1:0] mn = w ? ext(XLEN'(32'h8000_0000), 1'b1, 1'b1) : (XLEN'(1) << (XLEN-1));
        logic [XLEN-1:0] r;
        spec = 1'b1;
        if (be == '0)                          r = rem ? ae : '1;
        else if (s && ae == mn && be == '1)    r = rem ? '0 : ae;
        else begin
            spec = 1'b0;
            if (s) r = rem ? $signed(ae) % $signed(be) : $signed(ae) / $signed(be);
            else   r = rem ? ae % be : ae / be;
        end
        return w ? ext(r, 1'b1, 1'b1) : r;
    endfunction

    function automatic int exp_lat(input logic w, input logic spec);
        int n = w ? 32 : XLEN;
        return (spec && FAST) ? 1 : n + 1;
    endfunction

    // Issue one request, wait for the result, check it, optionally stall the consumer.
    task automatic run_op(input string tag, input div_op_e op, input logic w,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int lat, input int hold);
        int cyc;
        logic rdy_bad;
        logic stable;
        logic [XLEN-1:0] held;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        div_op_i = op; word_32_i = w; src_a_i = a; src_b_i = b; valid_i = 1'b1;
        check({tag, "_rdy_idle"}, ready_o, 1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        cyc = 1;
        rdy_bad = 1'b0;
        while (!valid_o && cyc < 200) begin
            if (ready_o) rdy_bad = 1'b1;
            @(posedge clk_i); #1;
            cyc++;
        end
        if (ready_o) rdy_bad = 1'b1;
        check({tag, "_valid"}, valid_o, 1);
        check({tag, "_lat"}, cyc, lat_q.pop_front());
        check({tag, "_rdy_busy"}, rdy_bad, 0);
        check({tag, "_res"}, result_o, exp_q.pop_front());
        if (hold > 0) begin
            held = result_o;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk_i); #1;
                if (result_o !== held || ready_o !== 1'b0 || valid_o !== 1'b1) stable = 1'b0;
            end
            check({tag, "_hold"}, stable, 1);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check({tag, "_ret_v"}, valid_o, 0);
        check({tag, "_ret_r"}, ready_o, 1);
    endtask

    task automatic run_model(input string tag, input div_op_e op, input logic w,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic spec;
        logic [XLEN-1:0] e;
        e = ref_res(op, w, a, b, spec);
        run_op(tag, op, w, a, b, e, exp_lat(w, spec), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic w;
        logic [XLEN-1:0] a, b;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_result", result_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

`ifndef RV64
        run_op("divs_m7_2", DIV_S, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rems_m7_2", REM_S, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("divu_100_7", DIV_U, 1'b0, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu_100_7", REM_U, 1'b0, 32'd100, 32'd7, 32'd2, 33, 5);
        run_op("divu_5_0", DIV_U, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, FAST ? 1 : 33, 0);
        run_op("rems_5_0", REM_S, 1'b0, 32'd5, 32'd0, 32'd5, FAST ? 1 : 33, 0);
        run_op("divs_ovf", DIV_S, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST ? 1 : 33, 0);
        run_op("rems_ovf", REM_S, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FAST ? 1 : 33, 0);
`else
        run_op("divs_w", DIV_S, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_op("divs_64", DIV_S, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 5);
        run_op("remu_w_0", REM_U, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000,
               64'hFFFF_FFFF_8000_0005, FAST ? 1 : 33, 0);
        run_op("divs_w_ovf", DIV_S, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, FAST ? 1 : 33, 0);
`endif

        // Flush together with a request in IDLE: nothing accepted.
        div_op_i = DIV_U; word_32_i = 1'b0; src_a_i = XLEN'(9); src_b_i = XLEN'(3);
        valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush_idle_rdy", ready_o, 1);

        // Flush mid-CALC: result discarded.
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_calc_rdy", ready_o, 1);
        seen = 0;
        repeat (40) begin
            if (valid_o) seen++;
            @(posedge clk_i); #1;
        end
        check("flush_no_valid", seen, 0);

        // Asynchronous reset mid-CALC, with a nonzero result still held.
        run_op("divu_pre_rst", DIV_U, 1'b0, XLEN'(77), XLEN'(7), XLEN'(11), (XLEN == 32) ? 33 : XLEN + 1, 0);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_ready", ready_o, 1);
        check("arst_valid", valid_o, 0);
        check("arst_result", result_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 10; i++) begin
            a = XLEN'({$urandom, $urandom});
            b = (i % 3 == 0) ? XLEN'($urandom_range(1, 50)) : XLEN'({$urandom, $urandom});
            if (i % 2 == 1) b = -b;
            if (i == 7) b = '0;
            w = (XLEN > 32) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_model("rand", div_op_e'($urandom_range(0, 3)), w, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
